// File: rtl/debounce_pkg.sv
// debounce_pkg: shared types and constants for the debounce block.
//   deb_state_t  - qualification FSM state encoding
//   BOUNCE_CNT_W - width of the optional bounce counter
// Also provides the `HIGH / `LOW polarity macros used for the ACT parameter
// when the surrounding build has not already defined them.
`ifndef HIGH
`define HIGH 1'b1
`endif
`ifndef LOW
`define LOW 1'b0
`endif

package debounce_pkg;

    typedef enum logic [1:0] {
        ST_INACT,
        CHK_ACT,
        ST_ACT,
        CHK_INACT
    } deb_state_t;

    localparam int BOUNCE_CNT_W = 8;

endpackage

// File: rtl/debounce_if.sv
// debounce_if: signal bundle between a raw-level source and its debouncer.
//   raw_in     - asynchronous raw level (driven by master)
//   level_out  - debounced level (driven by slave)
//   busy       - candidate transition under qualification (driven by slave)
//   bounce_cnt - aborted-qualification count, only with PARAMMOD_DEBOUNCE_BOUNCE_CNT_EN
// Modports: master = source/consumer side, slave = debounce block.
interface debounce_if;
    import debounce_pkg::*;

    logic raw_in;
    logic level_out;
    logic busy;
`ifdef PARAMMOD_DEBOUNCE_BOUNCE_CNT_EN
    logic [BOUNCE_CNT_W-1:0] bounce_cnt;
`endif

    modport master (
        output raw_in,
        input  level_out,
        input  busy
`ifdef PARAMMOD_DEBOUNCE_BOUNCE_CNT_EN
        , input bounce_cnt
`endif
    );

    modport slave (
        input  raw_in,
        output level_out,
        output busy
`ifdef PARAMMOD_DEBOUNCE_BOUNCE_CNT_EN
        , output bounce_cnt
`endif
    );
endinterface

// File: rtl/debounce_sync_ff.sv
// sync_ff: generic multi-flop synchroniser.
//   clk   - destination clock
//   reset - synchronous, active-high; every stage loads RST_VAL
//   d     - asynchronous input
//   q     - synchronised output (last stage)
// STAGES must be >= 2.
module sync_ff #(
    parameter int STAGES  = 2,
    parameter bit RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] ff;

    always_ff @(posedge clk) begin
        if (reset) ff <= {STAGES{RST_VAL}};
        else       ff <= {ff[STAGES-2:0], d};
    end

    assign q = ff[STAGES-1];
endmodule

// File: rtl/debounce.sv
// debounce: turns a bouncy asynchronous level into a clean clk-synchronous level.
//   clk   - clock
//   reset - synchronous, active-high
//   bus   - debounce_if.slave: raw_in in; level_out, busy (and bounce_cnt) out
// Parameters: ACT (active level), SYNC_STAGES (2..4), STABLE_CYCLES (>=1).
// Optional feature macro: PARAMMOD_DEBOUNCE_BOUNCE_CNT_EN adds a saturating
// 8-bit count of aborted qualifications on bus.bounce_cnt.
module debounce
    import debounce_pkg::*;
#(
    parameter bit ACT           = `HIGH,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    debounce_if.slave bus
);
    localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic             s;
    logic             s_act;
    deb_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             level_q;
    logic             busy_q;
    logic             abort;

    sync_ff #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (!ACT)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.raw_in),
        .q     (s)
    );

    assign s_act = (s == ACT);

    // A candidate transition is dropped as soon as the synchronised level
    // disagrees with it.
    assign abort = ((state == CHK_ACT) && !s_act) || ((state == CHK_INACT) && s_act);

    // Outputs are loaded together with the next state so they stay pure flops.
    // The deviation check has priority over the count compare, and the
    // compare happens before the increment so cnt never wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_INACT;
            cnt     <= '0;
            level_q <= !ACT;
            busy_q  <= 1'b0;
        end else begin
            case (state)
                ST_INACT: if (s_act) begin
                    state  <= CHK_ACT;
                    cnt    <= '0;
                    busy_q <= 1'b1;
                end
                CHK_ACT: if (!s_act) begin
                    state  <= ST_INACT;
                    busy_q <= 1'b0;
                end else if (cnt == CNT_MAX) begin
                    state   <= ST_ACT;
                    level_q <= ACT;
                    busy_q  <= 1'b0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                ST_ACT: if (!s_act) begin
                    state  <= CHK_INACT;
                    cnt    <= '0;
                    busy_q <= 1'b1;
                end
                CHK_INACT: if (s_act) begin
                    state  <= ST_ACT;
                    busy_q <= 1'b0;
                end else if (cnt == CNT_MAX) begin
                    state   <= ST_INACT;
                    level_q <= !ACT;
                    busy_q  <= 1'b0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                default: begin
                    state   <= ST_INACT;
                    level_q <= !ACT;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.level_out = level_q;
    assign bus.busy      = busy_q;

`ifdef PARAMMOD_DEBOUNCE_BOUNCE_CNT_EN
    logic [BOUNCE_CNT_W-1:0] bounce_q;

    always_ff @(posedge clk) begin
        if (reset)                    bounce_q <= '0;
        else if (abort && !(&bounce_q)) bounce_q <= bounce_q + 1'b1;
    end

    assign bus.bounce_cnt = bounce_q;
`else
    logic unused_abort;
    assign unused_abort = abort;
`endif
endmodule

// File: tb/tb_debounce.sv
module tb_debounce;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // Default instance (ACT high, 2 sync stages, 16 stable cycles).
    debounce_if u_if ();
    debounce #(.ACT(1'b1), .SYNC_STAGES(2), .STABLE_CYCLES(16)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if)
    );

    // Active-low instance with single-cycle qualification.
    debounce_if u_if_lo ();
    debounce #(.ACT(1'b0), .SYNC_STAGES(2), .STABLE_CYCLES(1)) u_dut_lo (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if_lo)
    );

    initial begin
        u_if.raw_in    = 1'b0;
        u_if_lo.raw_in = 1'b1;
    end

    // One clock edge, then settle so outputs are sampled away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        u_if.raw_in    = 1'b0;
        u_if_lo.raw_in = 1'b1;
        repeat (3) step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        u_if.raw_in    = 1'b1;
        u_if_lo.raw_in = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            step();
            checks++;
            if (u_if.level_out !== 1'b0) begin
                errors++;
                $display("FAIL reset_level cyc %0d got %b exp 0", k, u_if.level_out);
            end
            checks++;
            if (u_if.busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_busy cyc %0d got %b exp 0", k, u_if.busy);
            end
            checks++;
            if (u_if_lo.level_out !== 1'b1) begin
                errors++;
                $display("FAIL reset_level_lo cyc %0d got %b exp 1", k, u_if_lo.level_out);
            end
`ifdef PARAMMOD_DEBOUNCE_BOUNCE_CNT_EN
            checks++;
            if (u_if.bounce_cnt !== 8'd0) begin
                errors++;
                $display("FAIL reset_bounce cyc %0d got %0d exp 0", k, u_if.bounce_cnt);
            end
`endif
        end
        u_if.raw_in    = 1'b0;
        u_if_lo.raw_in = 1'b1;
        reset          = 1'b0;
    endtask

    // Raw high set before edge 1; level expected from cycle 19, busy in 3..18.
    task automatic check_rise(input string tag);
        logic exp_l, exp_b;
        for (int k = 1; k <= 22; k++) begin
            step();
            exp_l = (k >= 19);
            exp_b = (k >= 3) && (k <= 18);
            checks++;
            if (u_if.level_out !== exp_l) begin
                errors++;
                $display("FAIL %s_level cyc %0d got %b exp %b", tag, k, u_if.level_out, exp_l);
            end
            checks++;
            if (u_if.busy !== exp_b) begin
                errors++;
                $display("FAIL %s_busy cyc %0d got %b exp %b", tag, k, u_if.busy, exp_b);
            end
        end
    endtask

    task automatic test_clean_edge();
        do_reset();
        step();
        u_if.raw_in = 1'b1;
        check_rise("clean");
    endtask

    task automatic test_glitch();
        do_reset();
        step();
        u_if.raw_in = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (k == 5) u_if.raw_in = 1'b0;
            checks++;
            if (u_if.level_out !== 1'b0) begin
                errors++;
                $display("FAIL glitch_level cyc %0d got %b exp 0", k, u_if.level_out);
            end
        end
        checks++;
        if (u_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL glitch_busy got %b exp 0", u_if.busy);
        end
`ifdef PARAMMOD_DEBOUNCE_BOUNCE_CNT_EN
        checks++;
        if (u_if.bounce_cnt !== 8'd1) begin
            errors++;
            $display("FAIL glitch_bounce got %0d exp 1", u_if.bounce_cnt);
        end
`endif
    endtask

    task automatic test_bounce_burst();
        do_reset();
        step();
        for (int p = 0; p < 4; p++) begin
            u_if.raw_in = 1'b1;
            repeat (3) begin
                step();
                checks++;
                if (u_if.level_out !== 1'b0) begin
                    errors++;
                    $display("FAIL burst_hi_level pulse %0d got %b exp 0", p, u_if.level_out);
                end
            end
            u_if.raw_in = 1'b0;
            repeat (2) begin
                step();
                checks++;
                if (u_if.level_out !== 1'b0) begin
                    errors++;
                    $display("FAIL burst_lo_level pulse %0d got %b exp 0", p, u_if.level_out);
                end
            end
        end
        u_if.raw_in = 1'b1;
        check_rise("burst");
`ifdef PARAMMOD_DEBOUNCE_BOUNCE_CNT_EN
        checks++;
        if (u_if.bounce_cnt !== 8'd4) begin
            errors++;
            $display("FAIL burst_bounce got %0d exp 4", u_if.bounce_cnt);
        end
`endif
    endtask

    // ACT low, STABLE_CYCLES=1: output follows raw after 4 edges each way.
    task automatic test_act_low();
        logic exp_l;
        do_reset();
        step();
        u_if_lo.raw_in = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            exp_l = (k >= 4) ? 1'b0 : 1'b1;
            checks++;
            if (u_if_lo.level_out !== exp_l) begin
                errors++;
                $display("FAIL lo_press cyc %0d got %b exp %b", k, u_if_lo.level_out, exp_l);
            end
        end
        u_if_lo.raw_in = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            exp_l = (k >= 4) ? 1'b1 : 1'b0;
            checks++;
            if (u_if_lo.level_out !== exp_l) begin
                errors++;
                $display("FAIL lo_release cyc %0d got %b exp %b", k, u_if_lo.level_out, exp_l);
            end
            checks++;
            if (u_if_lo.busy !== (k == 3)) begin
                errors++;
                $display("FAIL lo_busy cyc %0d got %b exp %b", k, u_if_lo.busy, (k == 3));
            end
        end
    endtask

    // Reset while qualifying (cnt=7 after edge 10); a downstream edge
    // detector on level_out must see no rising edge.
    task automatic test_reset_mid_chk();
        logic prev;
        int   pulses;
        pulses = 0;
        do_reset();
        prev = u_if.level_out;
        step();
        u_if.raw_in = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (u_if.level_out === 1'b1 && prev === 1'b0) pulses++;
            prev = u_if.level_out;
        end
        checks++;
        if (u_if.busy !== 1'b1) begin
            errors++;
            $display("FAIL midchk_busy_pre got %b exp 1", u_if.busy);
        end
        reset = 1'b1;
        step();
        if (u_if.level_out === 1'b1 && prev === 1'b0) pulses++;
        prev = u_if.level_out;
        checks++;
        if (u_if.level_out !== 1'b0) begin
            errors++;
            $display("FAIL midchk_level got %b exp 0", u_if.level_out);
        end
        checks++;
        if (u_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL midchk_busy got %b exp 0", u_if.busy);
        end
        reset       = 1'b0;
        u_if.raw_in = 1'b0;
        repeat (20) begin
            step();
            if (u_if.level_out === 1'b1 && prev === 1'b0) pulses++;
            prev = u_if.level_out;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL midchk_pulses got %0d exp 0", pulses);
        end
    endtask

    initial begin
        test_reset();
        test_clean_edge();
        test_glitch();
        test_bounce_burst();
        test_act_low();
        test_reset_mid_chk();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
